// File: rtl/systolic_mm_sequencer_if.sv
// ============================================================================
// systolic_mm_sequencer_if : job handshake, operand, feeder and result bus
// Revision 1.0
// ============================================================================
`default_nettype none

interface systolic_mm_sequencer_if #(
    parameter int WIDTH     = 4,
    parameter int N         = 3,
    parameter int ACC_WIDTH = 10
);
    logic                     START_VALID;
    logic                     START_READY;
    logic [N*N*WIDTH-1:0]     A_IN;
    logic [N*N*WIDTH-1:0]     B_IN;
    logic                     ABORT;
    logic [N*N*WIDTH-1:0]     A_HELD;
    logic [N*N*WIDTH-1:0]     B_HELD;
    logic                     FEED_RST_N;
    logic                     FEED_ENABLE;
    logic [N*N*ACC_WIDTH-1:0] C_IN;
    logic [N*N*ACC_WIDTH-1:0] C_OUT;
    logic                     C_VALID;
    logic                     C_READY;
    logic                     BUSY;
    logic [7:0]               JOB_COUNT;

    modport master (
        output START_VALID, A_IN, B_IN, ABORT, C_IN, C_READY,
        input  START_READY, A_HELD, B_HELD, FEED_RST_N, FEED_ENABLE,
               C_OUT, C_VALID, BUSY, JOB_COUNT
    );

    modport slave (
        input  START_VALID, A_IN, B_IN, ABORT, C_IN, C_READY,
        output START_READY, A_HELD, B_HELD, FEED_RST_N, FEED_ENABLE,
               C_OUT, C_VALID, BUSY, JOB_COUNT
    );
endinterface

`default_nettype wire

// File: rtl/systolic_mm_sequencer.sv
// ============================================================================
// systolic_mm_sequencer : job controller for the NxN systolic matrix multiply
// Revision 1.0
// ============================================================================
`default_nettype none

module systolic_mm_sequencer #(
    parameter int WIDTH          = 4,
    parameter int N              = 3,
    parameter int ACC_WIDTH      = 10,
    parameter int COMPUTE_CYCLES = 10
) (
    input  logic                   CLK,
    input  logic                   RST,
    systolic_mm_sequencer_if.slave bus
);
    localparam int OPW   = N * N * WIDTH;
    localparam int CW    = N * N * ACC_WIDTH;
    localparam int CNT_W = $clog2(COMPUTE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COMPUTE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OPW-1:0]   a_held_q, a_held_d;
    logic [OPW-1:0]   b_held_q, b_held_d;
    logic [CW-1:0]    c_out_q, c_out_d;
    logic [7:0]       job_cnt_q, job_cnt_d;
    logic             feed_rst_n_q, feed_rst_n_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            a_held_q     <= '0;
            b_held_q     <= '0;
            c_out_q      <= '0;
            job_cnt_q    <= '0;
            feed_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_held_q     <= a_held_d;
            b_held_q     <= b_held_d;
            c_out_q      <= c_out_d;
            job_cnt_q    <= job_cnt_d;
            feed_rst_n_q <= feed_rst_n_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_held_d  = a_held_q;
        b_held_d  = b_held_q;
        c_out_d   = c_out_q;
        job_cnt_d = job_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.START_VALID) begin
                    a_held_d = bus.A_IN;
                    b_held_d = bus.B_IN;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = bus.ABORT ? S_IDLE : S_COMPUTE;
            end
            S_COMPUTE: begin
                if (bus.ABORT) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                // An abort here must leave the previous result untouched.
                if (bus.ABORT) begin
                    state_d = S_IDLE;
                end else begin
                    c_out_d = bus.C_IN;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.C_READY) begin
                    state_d   = S_IDLE;
                    job_cnt_d = job_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Registered from the next state so the clear is a clean one-cycle flop pulse.
        feed_rst_n_d = (state_d != S_LOAD);
    end

    assign bus.START_READY = (state_q == S_IDLE);
    assign bus.BUSY        = (state_q != S_IDLE);
    assign bus.FEED_ENABLE = (state_q == S_COMPUTE);
    assign bus.C_VALID     = (state_q == S_DONE);
    assign bus.FEED_RST_N  = feed_rst_n_q;
    assign bus.A_HELD      = a_held_q;
    assign bus.B_HELD      = b_held_q;
    assign bus.C_OUT       = c_out_q;
    assign bus.JOB_COUNT   = job_cnt_q;

endmodule

`default_nettype wire
